// File: rtl/washer_btn_conditioner.sv
// Front-panel button conditioner: per-channel 2-flop synchroniser, debounce,
// press/release edge pulses and a one-shot long-press pulse, all registered.
module washer_btn_conditioner #(
  parameter int N_BTN       = 5,
  parameter int DEB_CYCLES  = 20,
  parameter int LONG_CYCLES = 2000,
  parameter int CNT_W       = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_BTN-1:0] btn_long,
  output logic             any_press
);

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_MAX  = CNT_W'(LONG_CYCLES);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);

  logic [N_BTN-1:0] s1_q, s1_d;
  logic [N_BTN-1:0] s2_q, s2_d;
  logic [N_BTN-1:0] level_q, level_d;
  logic [N_BTN-1:0] press_q, press_d;
  logic [N_BTN-1:0] release_q, release_d;
  logic [N_BTN-1:0] long_q, long_d;
  logic             any_press_q, any_press_d;
  logic [CNT_W-1:0] dcnt_q [N_BTN];
  logic [CNT_W-1:0] dcnt_d [N_BTN];
  logic [CNT_W-1:0] hcnt_q [N_BTN];
  logic [CNT_W-1:0] hcnt_d [N_BTN];
  logic [N_BTN-1:0] toggle;

  always_comb begin
    s1_d      = btn_raw;
    s2_d      = s1_q;
    toggle    = '0;
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    long_d    = '0;
    for (int i = 0; i < N_BTN; i++) begin
      dcnt_d[i] = '0;
      hcnt_d[i] = '0;
      // A sample matching the current level is treated as bounce and restarts the count.
      toggle[i] = (s2_q[i] != level_q[i]) && (dcnt_q[i] == DEB_LAST);
      if ((s2_q[i] != level_q[i]) && !toggle[i]) begin
        dcnt_d[i] = dcnt_q[i] + 1'b1;
      end
      level_d[i]   = level_q[i] ^ toggle[i];
      press_d[i]   = toggle[i] & ~level_q[i];
      release_d[i] = toggle[i] & level_q[i];
      // Hold counter runs only across a stable held level; it saturates so the long pulse fires once.
      if (level_q[i] && !toggle[i]) begin
        hcnt_d[i] = (hcnt_q[i] < LONG_MAX) ? hcnt_q[i] + 1'b1 : hcnt_q[i];
        long_d[i] = (hcnt_q[i] == LONG_LAST);
      end
    end
    any_press_d = |press_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q        <= '0;
      s2_q        <= '0;
      level_q     <= '0;
      press_q     <= '0;
      release_q   <= '0;
      long_q      <= '0;
      any_press_q <= 1'b0;
      for (int i = 0; i < N_BTN; i++) begin
        dcnt_q[i] <= '0;
        hcnt_q[i] <= '0;
      end
    end else begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      level_q     <= level_d;
      press_q     <= press_d;
      release_q   <= release_d;
      long_q      <= long_d;
      any_press_q <= any_press_d;
      for (int i = 0; i < N_BTN; i++) begin
        dcnt_q[i] <= dcnt_d[i];
        hcnt_q[i] <= hcnt_d[i];
      end
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign btn_long    = long_q;
  assign any_press   = any_press_q;

endmodule
